// File: rtl/i2c_pkg.sv
// Shared FSM state encoding and bus-level constants for the I2C register target.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the raw SCL/SDA bus levels and derives the SCL edge and
// START/STOP condition strobes used by the target FSM.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // NOTE: non-blocking assignments make every stage sample its pre-edge
    // neighbour, so the chain really is SYNC_STAGES flops deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    // SCL must be high on both sides of the SDA transition to qualify.
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_hist_q;
    assign scl_fall_o = ~scl_s & scl_hist_q;
    assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register file with an auto-incrementing
// pointer: write [addr|0, ptr, data...], read [addr|1, data...].
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        sda_drive_out,
    output logic                        busy,
    output logic                        wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic [7:0]                  wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_index,
    output logic [7:0]                  dbg_data
);

    localparam int IW = $clog2(NUM_REGS);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    i2c_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          full_q, full_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tx_q, tx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          sda_q, sda_d;
    logic          busy_q, busy_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic [IW-1:0] wr_index_q, wr_index_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          reg_we;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    cur_byte;

    assign cur_byte = regs_q[ptr_q];

    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        full_d     = full_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        reg_we     = 1'b0;

        if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (state_q inside {ADDR, PTR, WDATA, RDATA}) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                full_d    = (bit_cnt_q == 3'd7);
            end
        end

        // Bytes complete on the 8th rise; all SDA changes wait for the next fall.
        if (scl_fall) begin
            case (state_q)
                ADDR: if (full_q) begin
                    full_d = 1'b0;
                    if (shift_q[7:1] == TARGET_ADDR) begin
                        state_d = ADDR_ACK;
                        sda_d   = I2C_ACK;
                        busy_d  = 1'b1;
                        rw_d    = shift_q[0];
                    end else begin
                        state_d = IGNORE;
                        sda_d   = I2C_NACK;
                    end
                end
                ADDR_ACK: begin
                    bit_cnt_d = 3'd0;
                    full_d    = 1'b0;
                    if (rw_q) begin
                        state_d = RDATA;
                        sda_d   = cur_byte[7];
                        tx_d    = {cur_byte[6:0], 1'b0};
                    end else begin
                        state_d = PTR;
                        sda_d   = 1'b1;
                    end
                end
                PTR: if (full_q) begin
                    full_d  = 1'b0;
                    ptr_d   = shift_q[IW-1:0];
                    state_d = PTR_ACK;
                    sda_d   = I2C_ACK;
                end
                PTR_ACK, WDATA_ACK: begin
                    state_d   = WDATA;
                    sda_d     = 1'b1;
                    bit_cnt_d = 3'd0;
                    full_d    = 1'b0;
                end
                WDATA: if (full_q) begin
                    full_d     = 1'b0;
                    reg_we     = 1'b1;
                    wr_pulse_d = 1'b1;
                    wr_index_d = ptr_q;
                    wr_data_d  = shift_q;
                    ptr_d      = ptr_q + IW'(1);
                    state_d    = WDATA_ACK;
                    sda_d      = I2C_ACK;
                end
                RDATA: begin
                    if (full_q) begin
                        full_d  = 1'b0;
                        sda_d   = 1'b1;
                        ptr_d   = ptr_q + IW'(1);
                        state_d = RDATA_ACK;
                    end else begin
                        sda_d = tx_q[7];
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                end
                RDATA_ACK: begin
                    bit_cnt_d = 3'd0;
                    full_d    = 1'b0;
                    if (shift_q[0] == I2C_ACK) begin
                        state_d = RDATA;
                        sda_d   = cur_byte[7];
                        tx_d    = {cur_byte[6:0], 1'b0};
                    end else begin
                        state_d = IGNORE;
                        sda_d   = I2C_NACK;
                    end
                end
                default: ;
            endcase
        end

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            full_d    = 1'b0;
            sda_d     = 1'b1;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            full_q     <= 1'b0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            full_q     <= full_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // NOTE: the register file is cleared on reset because hosts rely on a
    // known all-zero image; this forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else if (reg_we) begin
            regs_q[ptr_q] <= shift_q;
        end
    end

    assign sda_drive_out = sda_q;
    assign busy          = busy_q;
    assign wr_pulse      = wr_pulse_q;
    assign wr_index      = wr_index_q;
    assign wr_data       = wr_data_q;
    assign dbg_data      = regs_q[dbg_index];

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h50, 7-bit target address matched on the bus.
REQ-002 SHALL have parameter NUM_REGS, default 16, register-file depth (power of two, 2..256).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on scl_in/sda_in (>=2).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; the design uses one clock, and reset is synchronous and active-high.
REQ-006 SHALL have port scl_in  input  1  resolved SCL bus level (asynchronous).
REQ-007 SHALL have port sda_in  input  1  resolved SDA bus level (asynchronous).
REQ-008 SHALL have port sda_drive_out  output  1  open-drain control: 0 = drive low, 1 = release (float to pullup).
REQ-009 SHALL have port busy  output  1  high from an address-matched START until the next STOP or START.
REQ-010 SHALL have port wr_pulse  output  1  one-cycle strobe per register write.
REQ-011 SHALL have port wr_index  output  $clog2(NUM_REGS)  register index written, valid with wr_pulse.
REQ-012 SHALL have port wr_data  output  8  byte written, valid with wr_pulse.
REQ-013 SHALL have port dbg_index  input  $clog2(NUM_REGS)  local read-back index.
REQ-014 SHALL have port dbg_data  output  8  regs[dbg_index], combinational.

Function
REQ-015 SHALL synchronize scl_in/sda_in through SYNC_STAGES flops, plus one history flop each for edge detection.
REQ-016 SHALL detect START as synced SDA 1->0 while SCL high, and STOP as SDA 0->1 while SCL high.
REQ-017 SHALL sample data bits on the synced SCL rising edge, MSB first, with a 3-bit bit counter.
REQ-018 SHALL change sda_drive_out only in the cycle after a detected SCL falling edge, except for the release on STOP/START.
REQ-019 SHALL implement the FSM with states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-020 SHALL transition from any state to ADDR on START, including repeated START, discarding any partial byte.
REQ-021 SHALL transition from any state to IDLE on STOP and release SDA on the following cycle.
REQ-022 ADDR: after 8 bits, address == TARGET_ADDR -> ADDR_ACK driving 0 for one SCL high period; mismatch -> IGNORE with SDA released (NACK).
REQ-023 ADDR_ACK with R/W=0 -> PTR; with R/W=1 -> RDATA, driving bit7 of regs[ptr] at the SCL falling edge that ends the ACK.
REQ-024 PTR: the received byte sets ptr to byte[$clog2(NUM_REGS)-1:0], upper bits ignored; PTR_ACK then ACKs -> WDATA.
REQ-025 WDATA: each full byte writes regs[ptr], pulses wr_pulse with the old ptr, increments ptr modulo NUM_REGS, then ACKs in WDATA_ACK.
REQ-026 RDATA: after 8 bits driven, SHALL release SDA, increment ptr modulo NUM_REGS, and sample master ACK on SCL rise in RDATA_ACK.
REQ-027 RDATA_ACK: master ACK (0) -> RDATA with the next byte; NACK (1) -> IGNORE with SDA released.
REQ-028 IGNORE SHALL hold SDA released until START or STOP.
REQ-029 SHALL never drive SCL; no clock stretching and no general call.
REQ-030 SHALL retain ptr across transactions, so a write of the pointer then a repeated START read returns regs[ptr].

Reset
REQ-031 On rst: state IDLE, sda_drive_out 1, busy 0, wr_pulse 0, wr_index 0, wr_data 0, ptr 0, all regs 8'h00, synchronizer and history flops 1.
REQ-032 rst asserted mid-transaction SHALL release SDA the next cycle; the module then waits in IDLE for a new START.

Structure
REQ-033 Shared package i2c_pkg SHALL hold the FSM state enum and constants I2C_ACK=1'b0 and I2C_NACK=1'b1.
REQ-034 Sub-module i2c_line_sync SHALL contain the synchronizer and the START/STOP/SCL-rise/SCL-fall detectors; all else stays in i2c_target_regs.

Verification
REQ-035 Write 0xA0, ptr 0x03, data 0x11, 0x22, STOP -> ACK on all four bytes; wr_pulse at index 3 (0x11) and 4 (0x22); dbg_data[4]=0x22.
REQ-036 Address 0x51 write -> SDA released at the ACK bit (NACK); no wr_pulse; busy stays 0.
REQ-037 Write 0xA0, ptr 0x0F, repeated START, 0xA1, read 2 bytes with ACK then NACK -> returns regs[15] then regs[0] (wrap); final ptr 1.
REQ-038 Write 0xA0, ptr 0x0F, data 0xAA, 0xBB -> regs[15]=0xAA, regs[0]=0xBB (wrap).
REQ-039 STOP issued after 4 data bits of a read -> sda_drive_out=1 within 1 cycle; state IDLE; no ptr change beyond the completed bytes.
REQ-040 rst asserted during ADDR_ACK with SDA held low -> sda_drive_out=1 next cycle; a following full write transaction succeeds.
